reg_dump_uart: RTL and testbench

//  Debug sink downstream of the Mips core. On request, walks the core's register-inspection

---
 rtl/reg_dump_pkg.sv | 15 +
 rtl/uart_tx_byte.sv | 77 +++++++
 rtl/reg_dump_uart.sv | 106 ++++++++++
 tb/tb_reg_dump_uart.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_dump_pkg.sv
// reg_dump_pkg: shared constants, FSM state encoding and hex digit encoder
package reg_dump_pkg;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam int CHARS_PER_REG = 10;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SEND   = 2'd2,
        ST_FINISH = 2'd3
    } state_e;
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction
endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 serializer; can accept the next byte in the last stop-bit cycle
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [1:0] PH_IDLE  = 2'd0;
    localparam logic [1:0] PH_START = 2'd1;
    localparam logic [1:0] PH_DATA  = 2'd2;
    localparam logic [1:0] PH_STOP  = 2'd3;
    logic [1:0]    ph_q, ph_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          tx_q, tx_d;
    logic          bit_end;
    assign bit_end = (ph_q != PH_IDLE) && (cnt_q == LAST);
    assign tx_done = (ph_q == PH_STOP) && bit_end;
    assign tx_busy = (ph_q != PH_IDLE) && !tx_done;
    assign tx      = tx_q;
    // next frame phase, baud count and line level; a start in the final stop cycle chains frames
    always_comb begin
        ph_d  = ph_q;
        cnt_d = (ph_q == PH_IDLE || bit_end) ? '0 : cnt_q + 1'b1;
        bit_d = bit_q;
        sh_d  = sh_q;
        tx_d  = tx_q;
        if (start && !tx_busy) begin
            ph_d  = PH_START;
            cnt_d = '0;
            sh_d  = data;
            tx_d  = 1'b0;
        end else if (bit_end) begin
            case (ph_q)
                PH_START: begin
                    ph_d  = PH_DATA;
                    bit_d = 3'd0;
                    tx_d  = sh_q[0];
                end
                PH_DATA: begin
                    ph_d  = (bit_q == 3'd7) ? PH_STOP : PH_DATA;
                    bit_d = bit_q + 3'd1;
                    sh_d  = {1'b0, sh_q[7:1]};
                    tx_d  = (bit_q == 3'd7) ? 1'b1 : sh_q[1];
                end
                default: begin
                    ph_d = PH_IDLE;
                    tx_d = 1'b1;
                end
            endcase
        end
    end
    // frame state; reset forces the line high at once, killing any frame in flight
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ph_q  <= PH_IDLE;
            cnt_q <= '0;
            bit_q <= '0;
            sh_q  <= '0;
            tx_q  <= 1'b1;
        end else begin
            ph_q  <= ph_d;
            cnt_q <= cnt_d;
            bit_q <= bit_d;
            sh_q  <= sh_d;
            tx_q  <= tx_d;
        end
    end
endmodule

// File: rtl/reg_dump_uart.sv
// reg_dump_uart: walks the core register port and streams each value as hex text over UART
module reg_dump_uart
    import reg_dump_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int NUM_REGS     = 32,
    parameter int READ_LAT     = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        dump_req,
    output logic [4:0]  addrout,
    input  logic [31:0] regout,
    output logic        tx,
    output logic        busy,
    output logic        done
);
    localparam int LW = $clog2(READ_LAT + 1);
    localparam logic [LW-1:0] LAT_LAST  = LW'(READ_LAT - 1);
    localparam logic [4:0]    LAST_ADDR = 5'(NUM_REGS - 1);
    localparam logic [3:0]    LAST_CHAR = 4'(CHARS_PER_REG - 1);
    state_e        state_q, state_d;
    logic [4:0]    addr_q, addr_d;
    logic [LW-1:0] lat_q, lat_d;
    logic [3:0]    idx_q, idx_d;
    logic          started_q, started_d;
    logic [31:0]   shadow_q, shadow_d;
    logic [3:0]    sel_idx;
    logic [4:0]    nib_pos;
    logic [3:0]    nib;
    logic [7:0]    char_byte;
    logic          tx_start, tx_busy, tx_done;
    assign sel_idx   = started_q ? idx_q + 4'd1 : 4'd0;
    assign nib_pos   = {~sel_idx[2:0], 2'b00};
    assign nib       = shadow_q[nib_pos +: 4];
    assign char_byte = (sel_idx == 4'd8) ? ASCII_CR : (sel_idx == 4'd9) ? ASCII_LF : hex_ascii(nib);
    assign tx_start  = (state_q == ST_SEND) && !tx_busy && (!started_q || (tx_done && idx_q != LAST_CHAR));
    assign addrout   = addr_q;
    assign busy      = (state_q == ST_WAIT) || (state_q == ST_SEND);
    assign done      = (state_q == ST_FINISH);
    uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clock   (clock),
        .reset   (reset),
        .start   (tx_start),
        .data    (char_byte),
        .tx      (tx),
        .tx_busy (tx_busy),
        .tx_done (tx_done)
    );
    // dump sequencing: settle the read, freeze it in the shadow, then emit ten characters
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        lat_d     = lat_q;
        idx_d     = idx_q;
        started_d = started_q;
        shadow_d  = shadow_q;
        case (state_q)
            ST_IDLE: if (dump_req) begin
                state_d = ST_WAIT;
                addr_d  = '0;
                lat_d   = '0;
            end
            ST_WAIT: begin
                lat_d = lat_q + 1'b1;
                if (lat_q == LAT_LAST) begin
                    shadow_d  = regout;
                    idx_d     = '0;
                    started_d = 1'b0;
                    lat_d     = '0;
                    state_d   = ST_SEND;
                end
            end
            ST_SEND: if (tx_start) begin
                started_d = 1'b1;
                idx_d     = sel_idx;
            end else if (tx_done) begin
                state_d = (addr_q == LAST_ADDR) ? ST_FINISH : ST_WAIT;
                addr_d  = (addr_q == LAST_ADDR) ? addr_q : addr_q + 5'd1;
                lat_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                addr_d  = '0;
            end
        endcase
    end
    // controller registers; reset abandons any dump in progress
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            lat_q     <= '0;
            idx_q     <= '0;
            started_q <= 1'b0;
            shadow_q  <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            lat_q     <= lat_d;
            idx_q     <= idx_d;
            started_q <= started_d;
            shadow_q  <= shadow_d;
        end
    end
endmodule

// File: tb/tb_reg_dump_uart.sv
// tb_reg_dump_uart: two dumpers (2 and 32 registers) checked by a UART decoder against a text model
module tb_reg_dump_uart;
    localparam int CPB = 4;
    localparam int NRS [2] = '{2, 32};
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req   [2];
    logic [4:0]  addr  [2];
    logic [31:0] rout  [2];
    logic [31:0] p1    [2];
    logic        tx    [2];
    logic        busy  [2];
    logic        done  [2];
    logic [31:0] mem   [2][32];
    int tot = 0, bad = 0, cyc = 0;
    bit rx_act [2];
    int rx_cnt [2], rx_pos [2], rx_ptr [2], prev_start [2];
    int nbytes [2], ndone [2], busy_cyc [2], last_len [2], naddr [2];
    bit prev_busy [2];
    logic [4:0]  prev_addr [2];
    logic [7:0]  sh [2];
    logic [31:0] line_val [2];
    string hexs [2];

    reg_dump_uart #(.CLKS_PER_BIT(CPB), .NUM_REGS(2), .READ_LAT(3)) dut0 (
        .clock(clock), .reset(reset), .dump_req(req[0]), .addrout(addr[0]),
        .regout(rout[0]), .tx(tx[0]), .busy(busy[0]), .done(done[0]));
    reg_dump_uart #(.CLKS_PER_BIT(CPB), .NUM_REGS(32), .READ_LAT(3)) dut1 (
        .clock(clock), .reset(reset), .dump_req(req[1]), .addrout(addr[1]),
        .regout(rout[1]), .tx(tx[1]), .busy(busy[1]), .done(done[1]));

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // register file with a two-stage registered read path
    always @(posedge clock) begin
        for (int g = 0; g < 2; g++) begin
            p1[g]   <= mem[g][addr[g]];
            rout[g] <= p1[g];
        end
    end

    task automatic chk(input string name, input longint act, input longint expv);
        tot++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic chks(input string name, input string act, input string expv);
        tot++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got \"%s\" want \"%s\"", name, act, expv);
        end
    endtask

    function automatic logic [7:0] exp_char(input logic [31:0] v, input int pos);
        string s;
        s = $sformatf("%08h", v);
        s = s.toupper();
        return pos < 8 ? s[pos] : (pos == 8 ? 8'h0d : 8'h0a);
    endfunction

    task automatic wait_done(input int g, input int lim);
        int n;
        n = 0;
        while (done[g] !== 1'b1 && n < lim) begin
            @(negedge clock);
            n++;
        end
        chk($sformatf("done_timeout%0d", g), n < lim, 1);
    endtask

    task automatic pulse(input int g);
        @(negedge clock) req[g] = 1'b1;
        @(negedge clock) req[g] = 1'b0;
    endtask

    // per-cycle invariants plus UART receive and byte-by-byte comparison against the text model
    always @(negedge clock) begin
        for (int g = 0; g < 2; g++) begin
            if (!reset) begin
                rx_act[g] = 0; rx_pos[g] = 0; rx_ptr[g] = 0;
                prev_busy[g] = 0; prev_addr[g] = '0;
            end else begin
                if (!busy[g]) chk($sformatf("idle_tx%0d", g), tx[g], 1);
                chk($sformatf("addr_range%0d", g), addr[g] <= 5'(NRS[g] - 1), 1);
                if (done[g]) begin
                    chk($sformatf("done_busy%0d", g), {prev_busy[g], busy[g]}, 2'b10);
                    ndone[g]++;
                    last_len[g] = busy_cyc[g];
                end
                if (busy[g]) busy_cyc[g] = prev_busy[g] ? busy_cyc[g] + 1 : 1;
                if (addr[g] != prev_addr[g]) begin
                    chk($sformatf("addr_step%0d", g), addr[g], busy[g] ? prev_addr[g] + 1 : 0);
                    chk($sformatf("addr_mid_frame%0d", g), rx_act[g], 0);
                    if (busy[g]) naddr[g]++;
                end
                if (!rx_act[g]) begin
                    if (tx[g] == 1'b0) begin
                        rx_act[g] = 1; rx_cnt[g] = 0;
                        if (rx_pos[g] == 0) line_val[g] = mem[g][rx_ptr[g]];
                        else chk($sformatf("char_gap%0d", g), cyc - prev_start[g], 10 * CPB);
                        prev_start[g] = cyc;
                    end
                end else begin
                    rx_cnt[g]++;
                    if (rx_cnt[g] % CPB == CPB / 2) begin
                        if (rx_cnt[g] / CPB == 0) chk($sformatf("start_bit%0d", g), tx[g], 0);
                        else if (rx_cnt[g] / CPB < 9) sh[g][rx_cnt[g] / CPB - 1] = tx[g];
                        else begin
                            chk($sformatf("stop_bit%0d", g), tx[g], 1);
                            chk($sformatf("rx_char%0d_r%0d_c%0d", g, rx_ptr[g], rx_pos[g]), sh[g], exp_char(line_val[g], rx_pos[g]));
                            nbytes[g]++;
                            if (rx_pos[g] < 8) hexs[g] = {hexs[g], $sformatf("%c", sh[g])};
                            rx_pos[g]++;
                            if (rx_pos[g] == 10) begin
                                rx_pos[g] = 0;
                                rx_ptr[g] = (rx_ptr[g] + 1) % NRS[g];
                            end
                        end
                    end
                    if (rx_cnt[g] == 10 * CPB - 1) rx_act[g] = 0;
                end
                prev_busy[g] = busy[g];
                prev_addr[g] = addr[g];
            end
        end
    end

    initial begin
        int h, n, d, edges;
        for (int g = 0; g < 2; g++) begin
            req[g] = 1'b0;
            hexs[g] = "";
            for (int i = 0; i < 32; i++) mem[g][i] = (g == 1) ? i * 32'h0101_0101 : 32'h0;
        end
        // reset state and a silent line while held in reset
        repeat (3) @(negedge clock);
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("rst_tx%0d", g), tx[g], 1);
            chk($sformatf("rst_busy%0d", g), busy[g], 0);
            chk($sformatf("rst_done%0d", g), done[g], 0);
            chk($sformatf("rst_addr%0d", g), addr[g], 0);
        end
        edges = 0;
        repeat (1000) @(negedge clock) if (tx[0] !== 1'b1 || tx[1] !== 1'b1) edges++;
        chk("rst_quiet", edges, 0);
        reset = 1'b1;
        repeat (5) @(negedge clock);

        // two-register dump
        mem[0][0] = 32'h0000_0000;
        mem[0][1] = 32'hDEAD_BEEF;
        h = hexs[0].len(); n = nbytes[0]; d = ndone[0];
        pulse(0);
        wait_done(0, 3000);
        repeat (5) @(negedge clock);
        chks("t2_text", hexs[0].substr(h, h + 15), "00000000DEADBEEF");
        chk("t2_bytes", nbytes[0] - n, 20);
        chk("t2_done_count", ndone[0] - d, 1);
        chk("t2_len_ok", last_len[0] >= 2 * (3 + 100 * CPB) - 4 && last_len[0] <= 2 * (3 + 100 * CPB) + 4, 1);

        // full 32-register dump
        h = hexs[1].len(); n = nbytes[1]; d = naddr[1];
        pulse(1);
        wait_done(1, 20000);
        repeat (5) @(negedge clock);
        chk("t3_bytes", nbytes[1] - n, 320);
        chk("t3_addr_steps", naddr[1] - d, 31);
        chks("t3_line0", hexs[1].substr(h, h + 7), "00000000");
        chks("t3_line10", hexs[1].substr(h + 80, h + 87), "0A0A0A0A");
        chks("t3_line31", hexs[1].substr(h + 248, h + 255), "1F1F1F1F");
        chk("t3_len_ok", last_len[1] >= 32 * (3 + 100 * CPB) - 64 && last_len[1] <= 32 * (3 + 100 * CPB) + 64, 1);

        // register changes mid-line must not disturb the line being sent
        mem[0][0] = 32'h0000_0001;
        mem[0][1] = 32'h1234_ABCD;
        h = hexs[0].len();
        pulse(0);
        n = 0;
        while (!(rx_ptr[0] == 1 && rx_pos[0] == 3) && n < 2000) begin
            @(negedge clock);
            n++;
        end
        chk("t4_reach", n < 2000, 1);
        mem[0][1] = 32'hFFFF_FFFF;
        wait_done(0, 2000);
        repeat (5) @(negedge clock);
        chks("t4_text", hexs[0].substr(h, h + 15), "000000011234ABCD");

        // requests while busy are dropped; a held request restarts right after done
        mem[0][0] = 32'h1111_1111;
        mem[0][1] = 32'h2222_2222;
        d = ndone[0];
        pulse(0);
        repeat (5) begin
            repeat (100) @(negedge clock);
            pulse(0);
        end
        wait_done(0, 2000);
        repeat (50) @(negedge clock);
        chk("t5_single_dump", ndone[0] - d, 1);
        chk("t5_idle_after", busy[0], 0);
        req[0] = 1'b1;
        wait_done(0, 2000);
        repeat (2) @(negedge clock);
        chk("t5_restart_busy", busy[0], 1);
        chk("t5_restart_addr", addr[0], 0);
        req[0] = 1'b0;
        wait_done(0, 2000);
        repeat (50) @(negedge clock);
        chk("t5_total_dumps", ndone[0] - d, 3);

        // reset in data bit 3 of char 5, then a clean restart from register 0
        mem[0][0] = 32'h0ABC_1234;
        mem[0][1] = 32'h55AA_55AA;
        pulse(0);
        n = 0;
        while (!(rx_act[0] && rx_ptr[0] == 0 && rx_pos[0] == 5 && rx_cnt[0] == 17) && n < 2000) begin
            @(negedge clock);
            n++;
        end
        chk("t6_reach", n < 2000, 1);
        chk("t6_bit3_low", tx[0], 0);
        #1 reset = 1'b0;
        #1;
        chk("t6_async_tx", tx[0], 1);
        chk("t6_async_busy", busy[0], 0);
        chk("t6_async_addr", addr[0], 0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (200) @(negedge clock);
        chk("t6_no_resume", busy[0], 0);
        h = hexs[0].len();
        pulse(0);
        wait_done(0, 2000);
        repeat (5) @(negedge clock);
        chks("t6_first_char", hexs[0].substr(h, h), "0");
        chks("t6_text", hexs[0].substr(h, h + 15), "0ABC123455AA55AA");

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end
endmodule
